// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: presents round keys 0..10 over a valid/ready
// handshake, computing each next key from the current one with four S-boxes.

module sbox (
  input  logic [7:0] a,
  output logic [7:0] s
);
  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] acc;
    p   = 8'h00;
    acc = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) p = p ^ acc;
      acc = {acc[6:0], 1'b0} ^ (acc[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] r;
    sq = x;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  logic [7:0] inv;

  always_comb begin
    inv = gf_inv(a);
    s   = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
  end
endmodule

module aes_key_expand (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic         rk_ready,
  output logic         rk_valid,
  output logic [3:0]   rk_round,
  output logic [127:0] rk,
  output logic         busy,
  output logic         done
);
  typedef enum logic {IDLE, RUN} state_t;

  state_t      state;
  logic [7:0]  rcon;
  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot, sub, t;
  logic [31:0] n0, n1, n2, n3;
  logic [7:0]  rcon_next;

  assign w0  = rk[127:96];
  assign w1  = rk[95:64];
  assign w2  = rk[63:32];
  assign w3  = rk[31:0];
  assign rot = {w3[23:0], w3[31:24]};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_subword
      sbox u_sbox (
        .a(rot[gi*8 +: 8]),
        .s(sub[gi*8 +: 8])
      );
    end
  endgenerate

  assign t  = sub ^ {rcon, 24'h0};
  assign n0 = w0 ^ t;
  assign n1 = n0 ^ w1;
  assign n2 = n1 ^ w2;
  assign n3 = n2 ^ w3;

  assign rcon_next = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rk       <= 128'h0;
      rk_round <= 4'd0;
      rk_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rcon     <= 8'h01;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            rk       <= key_in;
            rk_round <= 4'd0;
            rcon     <= 8'h01;
            rk_valid <= 1'b1;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          if (rk_ready) begin
            if (rk_round == 4'd10) begin
              // Final key consumed; the last key stays on rk but is no longer valid.
              rk_valid <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              state    <= IDLE;
            end else begin
              rk       <= {n0, n1, n2, n3};
              rk_round <= rk_round + 4'd1;
              rcon     <= rcon_next;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/aes_key_expand.md
# aes_key_expand

Iterative AES-128 key schedule. Accepts a 128-bit cipher key and emits round keys 0..10, one per accepted handshake. Sits directly downstream of the byte substitution lookup: it instantiates four `sbox` copies for SubWord. Its round-key stream feeds the AddRoundKey stage of the round datapath.

## Interface
Parameters:
- none; AES-128 only, with a fixed 10-round schedule.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request a new expansion; sampled only in IDLE.
- `key_in`  in  128  cipher key, captured on an accepted `start`. `key_in[127:120]` is byte 0.
- `rk_ready`  in  1  consumer accepts the current round key.
- `rk_valid`  out  1  `rk`/`rk_round` hold a valid round key.
- `rk_round`  out  4  index of the presented round key, 0..10.
- `rk`  out  128  round key, in the same byte order as `key_in`.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse after round key 10 is accepted.

## Operation
- Words: `w0=rk[127:96]`, `w1=rk[95:64]`, `w2=rk[63:32]`, `w3=rk[31:0]`.
- Next-key combinational path:
  - `rot = {w3[23:0], w3[31:24]}`.
  - `sub` = the four `sbox` instances applied to the bytes of `rot`.
  - `t = sub ^ {rcon, 24'h0}`.
  - `n0=w0^t`, `n1=n0^w1`, `n2=n1^w2`, `n3=n2^w3`. All operations are bitwise XOR; there is no arithmetic carry.
- `rcon` is a registered byte. Its value is 8'h01 when `rk_round`=0 is presented. Each advance updates it as xtime: `{rcon[6:0],1'b0} ^ (rcon[7] ? 8'h1b : 8'h00)`. This gives the sequence 01,02,04,08,10,20,40,80,1b,36.
- FSM states:
  - IDLE: `busy`=0, `rk_valid`=0. On `start`=1:
    - `rk`<=`key_in`, `rk_round`<=0, `rcon`<=8'h01.
    - Go to RUN.
  - RUN: `busy`=1, `rk_valid`=1.
    - On `rk_valid & rk_ready` with `rk_round`<10: `rk`<=`{n0,n1,n2,n3}`, `rk_round`<=`rk_round`+1, `rcon`<=xtime(`rcon`).
    - On `rk_valid & rk_ready` with `rk_round`==10: go to IDLE, `done`<=1 for one cycle, `rk_valid`<=0.
    - With `rk_ready`=0: hold `rk`, `rk_round`, `rcon` unchanged; `rk_valid` stays 1.
- `start` while in RUN is ignored; there is no restart mid-expansion.
- `key_in` is don't-care except in the cycle `start` is accepted.
- `rk_round` never exceeds 10. Values 11..15 are unreachable, and there is no wrap to 0 inside RUN.

## Timing
- Reset values (asynchronous, immediate on `rst`=1):
  - `rk_valid`=0, `rk_round`=0, `rk`=128'h0, `busy`=0, `done`=0.
  - Internal `rcon`=8'h01, state=IDLE.
- Reset mid-RUN aborts the expansion. Outputs return to their reset values in the same cycle, and no `done` is produced.
- Latency: `start` accepted at edge N gives `rk_valid`=1 with round 0 after edge N. The earliest next round key appears one cycle after each handshake.
- Throughput: one round key per cycle with `rk_ready` held at 1. Round 10 is presented 10 cycles after round 0.
- `done` is asserted in the cycle after the round-10 handshake. In that same cycle `busy`=0 and `rk_valid`=0.
- `start` asserted in the cycle `done`=1 is accepted, since the FSM is already in IDLE.
- The critical path is sbox depth plus three XOR levels; no pipelining is required.
- `rk` is registered; no output is combinationally dependent on inputs.

## Test plan
- FIPS-197 key with `rk_ready`=1. Stimulus: `key_in`=2b7e151628aed2a6abf7158809cf4f3c, one-cycle `start`. Required response:
  - round 0 = the key;
  - round 1 = a0fafe1788542cb123a339392a6c7605;
  - round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6;
  - `done` one cycle later, 11 handshakes total.
- All-zero key. Required response:
  - round 1 = 62636363626363636263636362636363;
  - round 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- Backpressure: same FIPS key with `rk_ready` random (about 50%). Required response:
  - `rk`/`rk_round` stable while `rk_ready`=0;
  - sequence identical to the first test;
  - no skipped or repeated round.
- `start` pulsed in RUN at round 4 with a different `key_in` -> ignored. The round-10 output still equals d014f9a8c9ee2589e13f0cc8b6630ca6.
- `rst` asserted mid-expansion at round 6 -> all outputs 0 immediately and no `done`. A new `start` then yields correct round 1 from cycle +1.
- Back-to-back: `start` asserted in the `done` cycle -> `rk_valid`=1 with `rk_round`=0 the next cycle, and the `rcon` sequence restarts at 01.
